// File: rtl/load_store_unit_if.sv
// Execute-stage request/response channel and data-cache port of the load/store unit.
// master drives the request (execute stage) or the cache access (load/store unit).
interface lsu_req_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned WCW  = 3;

  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [WCW-1:0]  req_width;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_error;

  modport master (
    output req_valid, req_write, req_width, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );
  modport slave (
    input  req_valid, req_write, req_width, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

interface lsu_mem_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned WCW  = 3;

  logic            mem_write_en;
  logic [WCW-1:0]  mem_width;
  logic [XLEN-1:0] mem_address;
  logic [XLEN-1:0] mem_in;
  logic [XLEN-1:0] mem_out;

  modport master (
    output mem_write_en, mem_width, mem_address, mem_in,
    input  mem_out
  );
  modport slave (
    input  mem_write_en, mem_width, mem_address, mem_in,
    output mem_out
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, native cache access when aligned,
// byte-by-byte split with little-endian reassembly when misaligned.
module load_store_unit #(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic      clk,
  input  logic      rst_n,
  lsu_req_if.slave  req,
  lsu_mem_if.master mem
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned WCW  = 3;
  localparam logic [WCW-1:0] W_B  = 3'b000;
  localparam logic [WCW-1:0] W_H  = 3'b001;
  localparam logic [WCW-1:0] W_W  = 3'b010;
  localparam logic [WCW-1:0] W_BU = 3'b100;
  localparam logic [WCW-1:0] W_HU = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_SPLIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic            wr_q, wr_d;
  logic [WCW-1:0]  width_q, width_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [1:0]      idx_q, idx_d;
  logic [XLEN-1:0] asm_q, asm_d;
  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic            resp_error_q, resp_error_d;
  logic            mem_we_q, mem_we_d;
  logic [WCW-1:0]  mem_width_q, mem_width_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_in_q, mem_in_d;

  function automatic logic [XLEN-1:0] extend(input logic [WCW-1:0] w, input logic [XLEN-1:0] d);
    case (w)
      W_B:     extend = {{24{d[7]}}, d[7:0]};
      W_H:     extend = {{16{d[15]}}, d[15:0]};
      W_W:     extend = d;
      W_BU:    extend = {24'b0, d[7:0]};
      W_HU:    extend = {16'b0, d[15:0]};
      default: extend = '0;
    endcase
  endfunction

  // Request decode, valid only while idle
  logic       accept, req_legal, req_misaligned, req_error;
  logic [1:0] last_idx, idx_next;
  logic [XLEN-1:0] asm_byte;

  assign accept         = req.req_valid && req_ready_q;
  assign req_legal      = req.req_write ? (req.req_width inside {W_B, W_H, W_W})
                                        : (req.req_width inside {W_B, W_H, W_W, W_BU, W_HU});
  assign req_misaligned = (req.req_width[1:0] == 2'b01 && req.req_addr[0]) ||
                          (req.req_width[1:0] == 2'b10 && req.req_addr[1:0] != 2'b00);
  assign req_error      = !req_legal || (req_misaligned && !SPLIT_MISALIGNED);
  assign last_idx       = (width_q[1:0] == 2'b00) ? 2'd0 : (width_q[1:0] == 2'b01) ? 2'd1 : 2'd3;
  assign idx_next       = idx_q + 2'd1;

  always_comb begin
    asm_byte = asm_q;
    asm_byte[{idx_q, 3'b000} +: 8] = mem.mem_out[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_q         <= 1'b0;
      width_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      idx_q        <= '0;
      asm_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_width_q  <= W_BU;
      mem_addr_q   <= '0;
      mem_in_q     <= '0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      width_q      <= width_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      idx_q        <= idx_d;
      asm_q        <= asm_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
      mem_we_q     <= mem_we_d;
      mem_width_q  <= mem_width_d;
      mem_addr_q   <= mem_addr_d;
      mem_in_q     <= mem_in_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_error)           state_d = S_RESP;
          else if (req_misaligned) state_d = S_SPLIT;
          else                     state_d = S_ACCESS;
        end
      end
      S_ACCESS: state_d = S_RESP;
      S_SPLIT:  if (idx_q == last_idx) state_d = S_RESP;
      S_RESP:   if (req.resp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath; write strobe defaults low
  always_comb begin
    wr_d         = wr_q;
    width_d      = width_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    idx_d        = idx_q;
    asm_d        = asm_q;
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;
    mem_we_d     = 1'b0;
    mem_width_d  = mem_width_q;
    mem_addr_d   = mem_addr_q;
    mem_in_d     = mem_in_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          wr_d    = req.req_write;
          width_d = req.req_width;
          addr_d  = req.req_addr;
          wdata_d = req.req_wdata;
          idx_d   = 2'd0;
          asm_d   = '0;
          case (state_d)
            S_ACCESS: begin
              mem_we_d    = req.req_write;
              mem_width_d = req.req_width;
              mem_addr_d  = req.req_addr;
              mem_in_d    = req.req_wdata;
            end
            S_SPLIT: begin
              mem_we_d    = req.req_write;
              mem_width_d = W_BU;
              mem_addr_d  = req.req_addr;
              mem_in_d    = {24'b0, req.req_wdata[7:0]};
            end
            default: begin
              resp_valid_d = 1'b1;
              resp_error_d = 1'b1;
              resp_rdata_d = '0;
            end
          endcase
        end
      end
      S_ACCESS: begin
        resp_valid_d = 1'b1;
        resp_error_d = 1'b0;
        resp_rdata_d = wr_q ? '0 : extend(width_q, mem.mem_out);
      end
      S_SPLIT: begin
        asm_d = asm_byte;
        if (idx_q == last_idx) begin
          resp_valid_d = 1'b1;
          resp_error_d = 1'b0;
          resp_rdata_d = wr_q ? '0 : extend(width_q, asm_byte);
        end else begin
          idx_d      = idx_next;
          mem_we_d   = wr_q;
          mem_addr_d = addr_q + XLEN'(idx_next);
          mem_in_d   = {24'b0, wdata_q[{idx_next, 3'b000} +: 8]};
        end
      end
      S_RESP: begin
        if (req.resp_ready) begin
          resp_valid_d = 1'b0;
          resp_rdata_d = '0;
          resp_error_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign req.req_ready    = req_ready_q;
  assign req.resp_valid   = resp_valid_q;
  assign req.resp_rdata   = resp_rdata_q;
  assign req.resp_error   = resp_error_q;
  assign mem.mem_write_en = mem_we_q;
  assign mem.mem_width    = mem_width_q;
  assign mem.mem_address  = mem_addr_q;
  assign mem.mem_in       = mem_in_q;
endmodule
